cache_mem_responder: RTL and testbench

- Shared backing-memory responder for the i-cache and d-cache block-refill interfaces: the memory end of the cache read/write/busywait protocol.
- Holds the block store, accepts one block request at a time, and arbitrates with fixed priority (d-cache over i-cache).
- Models a fixed access latency and returns 128-bit blocks.
- Sits below icache and dcache in the cpu top and replaces the two separate memory models.

---
 rtl/cache_mem_responder.sv | 139 +++++++++++++
 tb/tb_cache_mem_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: shared 128-bit block store serving i-cache and d-cache refills,
// one transaction at a time, d-cache priority, fixed access latency.
`default_nettype none

module cache_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [127:0]      i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [127:0]      d_writedata,
    output logic [127:0]      d_readdata,
    output logic              d_busywait
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GR_NONE = 2'd0,
        GR_D    = 2'd1,
        GR_I    = 2'd2
    } grant_t;

    state_t              state, state_nxt;
    grant_t              grant, grant_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [127:0]        wdata, wdata_nxt;
    logic                wr, wr_nxt;

    logic [127:0]        store [0:DEPTH-1];

    logic                d_req;
    logic                complete;

    assign d_req    = d_read | d_write;
    assign complete = (state == ST_BUSY) && (cnt == 4'd0);

    assign d_busywait = d_req  & ~((state == ST_RESP) && (grant == GR_D));
    assign i_busywait = i_read & ~((state == ST_RESP) && (grant == GR_I));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            grant <= GR_NONE;
            cnt   <= 4'd0;
            addr  <= '0;
            wdata <= '0;
            wr    <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            cnt   <= cnt_nxt;
            addr  <= addr_nxt;
            wdata <= wdata_nxt;
            wr    <= wr_nxt;
        end
    end

    // Request, address and data are captured only at grant; later input changes are ignored.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        cnt_nxt   = cnt;
        addr_nxt  = addr;
        wdata_nxt = wdata;
        wr_nxt    = wr;
        case (state)
            ST_IDLE: begin
                if (d_req) begin
                    grant_nxt = GR_D;
                    addr_nxt  = d_address;
                    wdata_nxt = d_writedata;
                    wr_nxt    = d_write;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = ST_BUSY;
                end else if (i_read) begin
                    grant_nxt = GR_I;
                    addr_nxt  = i_address;
                    wr_nxt    = 1'b0;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                grant_nxt = GR_NONE;
                state_nxt = ST_IDLE;
            end
            default: begin
                grant_nxt = GR_NONE;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The store has no reset; a reset during BUSY drops state before the completion edge.
    always_ff @(posedge clk) begin
        if (complete && wr) begin
            store[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_readdata <= '0;
            d_readdata <= '0;
        end else if (complete && !wr) begin
            if (grant == GR_D) begin
                d_readdata <= store[addr];
            end else if (grant == GR_I) begin
                i_readdata <= store[addr];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench: LATENCY=4 instance (a_*) and LATENCY=1 instance (b_*) against a block-store model.
`default_nettype none

module tb_cache_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_i_read = 0, a_d_read = 0, a_d_write = 0;
    logic [9:0]   a_i_address = 0, a_d_address = 0;
    logic [127:0] a_d_writedata = 0, a_i_readdata, a_d_readdata;
    logic         a_i_busywait, a_d_busywait;

    logic         b_i_read = 0, b_d_read = 0, b_d_write = 0;
    logic [9:0]   b_i_address = 0, b_d_address = 0;
    logic [127:0] b_d_writedata = 0, b_i_readdata, b_d_readdata;
    logic         b_i_busywait, b_d_busywait;

    cache_mem_responder #(.ADDR_W(10), .LATENCY(4)) dut_a (
        .clk(clk), .reset(rst_n),
        .i_read(a_i_read), .i_address(a_i_address), .i_readdata(a_i_readdata), .i_busywait(a_i_busywait),
        .d_read(a_d_read), .d_write(a_d_write), .d_address(a_d_address), .d_writedata(a_d_writedata),
        .d_readdata(a_d_readdata), .d_busywait(a_d_busywait)
    );

    cache_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut_b (
        .clk(clk), .reset(rst_n),
        .i_read(b_i_read), .i_address(b_i_address), .i_readdata(b_i_readdata), .i_busywait(b_i_busywait),
        .d_read(b_d_read), .d_write(b_d_write), .d_address(b_d_address), .d_writedata(b_d_writedata),
        .d_readdata(b_d_readdata), .d_busywait(b_d_busywait)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: block contents and each port's last returned block.
    logic [127:0] mdl [0:1023];
    logic [127:0] exp_ai, exp_ad;
    logic [127:0] r1, r2;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request on dut_a, wait until its busywait falls (the RESP cycle); request stays high.
    task automatic a_txn(input bit use_i, input bit rd, input bit wr, input logic [9:0] ad,
                         input logic [127:0] data, output bit bw0, output int edges);
        if (use_i) begin
            a_i_read = 1'b1; a_i_address = ad;
        end else begin
            a_d_read = rd; a_d_write = wr; a_d_address = ad; a_d_writedata = data;
        end
        #1;
        bw0 = use_i ? a_i_busywait : a_d_busywait;
        edges = 0;
        do begin
            tick();
            edges++;
        end while ((use_i ? a_i_busywait : a_d_busywait) && edges < 40);
    endtask

    task automatic a_drop();
        a_i_read = 0; a_d_read = 0; a_d_write = 0;
    endtask

    task automatic b_txn(input bit use_i, input bit wr, input logic [9:0] ad,
                         input logic [127:0] data, output int edges);
        if (use_i) begin
            b_i_read = 1'b1; b_i_address = ad;
        end else begin
            b_d_write = wr; b_d_read = ~wr; b_d_address = ad; b_d_writedata = data;
        end
        edges = 0;
        do begin
            tick();
            edges++;
        end while ((use_i ? b_i_busywait : b_d_busywait) && edges < 40);
        b_i_read = 0; b_d_read = 0; b_d_write = 0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (a_i_readdata !== 128'd0) begin n_fail++; $display("FAIL reset_a_i_readdata got %h want 0", a_i_readdata); end
        n_checks++; if (a_d_readdata !== 128'd0) begin n_fail++; $display("FAIL reset_a_d_readdata got %h want 0", a_d_readdata); end
        n_checks++; if (a_i_busywait !== 1'b0 || a_d_busywait !== 1'b0) begin n_fail++; $display("FAIL reset_a_busywait got %b%b want 00", a_i_busywait, a_d_busywait); end
        n_checks++; if (b_i_readdata !== 128'd0 || b_d_readdata !== 128'd0) begin n_fail++; $display("FAIL reset_b_readdata got %h %h want 0", b_i_readdata, b_d_readdata); end
        exp_ai = '0; exp_ad = '0;
    endtask

    task automatic test_write_read();
        bit bw0; int e;
        logic [127:0] v = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        a_txn(0, 0, 1, 10'h012, v, bw0, e);
        mdl[10'h012] = v;
        n_checks++; if (bw0 !== 1'b1) begin n_fail++; $display("FAIL wr_busy_at_raise got %b want 1", bw0); end
        n_checks++; if (e != 5) begin n_fail++; $display("FAIL wr_latency got %0d edges want 5", e); end
        n_checks++; if (a_d_readdata !== exp_ad) begin n_fail++; $display("FAIL wr_readdata_held got %h want %h", a_d_readdata, exp_ad); end
        a_drop(); tick();
        a_txn(0, 1, 0, 10'h012, '0, bw0, e);
        exp_ad = mdl[10'h012];
        n_checks++; if (e != 5) begin n_fail++; $display("FAIL rd_latency got %0d edges want 5", e); end
        n_checks++; if (a_d_readdata !== exp_ad) begin n_fail++; $display("FAIL rd_data got %h want %h", a_d_readdata, exp_ad); end
        a_drop(); tick();
    endtask

    task automatic test_reset_mid_write();
        bit bw0; int e;
        a_d_write = 1; a_d_address = 10'h012; a_d_writedata = ~mdl[10'h012];
        tick(); tick(); tick();
        rst_n = 1'b0; a_drop();
        #1;
        n_checks++; if (a_d_readdata !== 128'd0 || a_i_readdata !== 128'd0) begin n_fail++; $display("FAIL async_reset_readdata got %h %h want 0", a_d_readdata, a_i_readdata); end
        tick();
        rst_n = 1'b1;
        exp_ad = '0; exp_ai = '0;
        tick();
        a_txn(0, 1, 0, 10'h012, '0, bw0, e);
        exp_ad = mdl[10'h012];
        n_checks++; if (a_d_readdata !== exp_ad) begin n_fail++; $display("FAIL aborted_write_block got %h want %h", a_d_readdata, exp_ad); end
        a_drop(); tick();
    endtask

    task automatic test_simultaneous();
        bit bw0; int e, de, ie;
        logic [127:0] dv, iv, ihold;
        r1 = rnd128(); r2 = rnd128();
        a_txn(0, 0, 1, 10'h005, r1, bw0, e); a_drop(); tick(); mdl[10'h005] = r1;
        a_txn(0, 0, 1, 10'h006, r2, bw0, e); a_drop(); tick(); mdl[10'h006] = r2;
        a_i_read = 1; a_i_address = 10'h005;
        a_d_read = 1; a_d_address = 10'h006;
        de = -1; ie = -1; dv = '0; iv = '0; ihold = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (de < 0 && !a_d_busywait) begin
                de = k; dv = a_d_readdata; ihold = a_i_readdata; a_d_read = 0;
            end
            if (a_i_read && !a_i_busywait) begin
                ie = k; iv = a_i_readdata; a_i_read = 0;
                break;
            end
        end
        a_drop();
        exp_ad = mdl[10'h006]; exp_ai = mdl[10'h005];
        n_checks++; if (de != 5) begin n_fail++; $display("FAIL arb_d_latency got %0d want 5", de); end
        n_checks++; if (ie != 11) begin n_fail++; $display("FAIL arb_i_latency got %0d want 11", ie); end
        n_checks++; if (dv !== exp_ad) begin n_fail++; $display("FAIL arb_d_data got %h want %h", dv, exp_ad); end
        n_checks++; if (iv !== exp_ai) begin n_fail++; $display("FAIL arb_i_data got %h want %h", iv, exp_ai); end
        n_checks++; if (ihold !== 128'd0) begin n_fail++; $display("FAIL arb_i_held got %h want 0", ihold); end
        tick();
    endtask

    task automatic test_read_write_both();
        bit bw0; int e;
        logic [127:0] v = {32{4'hA}};
        a_txn(0, 1, 1, 10'h020, v, bw0, e);
        mdl[10'h020] = v;
        n_checks++; if (a_d_readdata !== exp_ad) begin n_fail++; $display("FAIL rw_readdata_held got %h want %h", a_d_readdata, exp_ad); end
        a_drop(); tick();
        a_txn(0, 1, 0, 10'h020, '0, bw0, e);
        exp_ad = mdl[10'h020];
        n_checks++; if (a_d_readdata !== exp_ad) begin n_fail++; $display("FAIL rw_store got %h want %h", a_d_readdata, exp_ad); end
        a_drop(); tick();
    endtask

    task automatic test_withdraw();
        bit bw0; int e;
        logic [127:0] w = rnd128();
        if (w == exp_ad) w = ~w;
        a_txn(0, 0, 1, 10'h030, w, bw0, e); a_drop(); tick(); mdl[10'h030] = w;
        a_d_read = 1; a_d_address = 10'h030;
        tick(); tick(); tick();
        a_d_read = 0;
        #1;
        n_checks++; if (a_d_busywait !== 1'b0) begin n_fail++; $display("FAIL withdraw_busywait got %b want 0", a_d_busywait); end
        tick(); tick();
        exp_ad = mdl[10'h030];
        n_checks++; if (a_d_readdata !== exp_ad) begin n_fail++; $display("FAIL withdraw_data got %h want %h", a_d_readdata, exp_ad); end
        a_txn(1, 0, 0, 10'h005, '0, bw0, e);
        exp_ai = mdl[10'h005];
        n_checks++; if (bw0 !== 1'b1) begin n_fail++; $display("FAIL withdraw_i_stall got %b want 1", bw0); end
        n_checks++; if (e != 6) begin n_fail++; $display("FAIL withdraw_return_idle got %0d edges want 6", e); end
        n_checks++; if (a_i_readdata !== exp_ai) begin n_fail++; $display("FAIL withdraw_i_data got %h want %h", a_i_readdata, exp_ai); end
        a_drop(); tick();
    endtask

    task automatic test_random();
        logic [9:0] pool [5] = '{10'h005, 10'h006, 10'h012, 10'h020, 10'h030};
        bit bw0; int e, op;
        logic [9:0] ad;
        logic [127:0] v;
        for (int n = 0; n < 30; n++) begin
            op = int'($urandom_range(0, 3));
            ad = pool[$urandom_range(0, 4)];
            v  = rnd128();
            a_txn(op == 3, op == 1 || op == 2, op == 0 || op == 2, ad, v, bw0, e);
            if (op == 0 || op == 2) mdl[ad] = v;
            else if (op == 1) exp_ad = mdl[ad];
            else exp_ai = mdl[ad];
            n_checks++; if (bw0 !== 1'b1 || e != 5) begin n_fail++; $display("FAIL rand_timing op %0d got bw=%b edges=%0d want 1/5", op, bw0, e); end
            n_checks++; if (a_d_readdata !== exp_ad || a_i_readdata !== exp_ai) begin
                n_fail++; $display("FAIL rand_data op %0d addr %h got d=%h i=%h want d=%h i=%h", op, ad, a_d_readdata, a_i_readdata, exp_ad, exp_ai);
            end
            a_drop(); tick();
        end
    endtask

    task automatic test_latency1();
        int e;
        logic [127:0] v0 = rnd128(), v1 = rnd128();
        b_txn(0, 1, 10'h000, v0, e);
        n_checks++; if (e != 2) begin n_fail++; $display("FAIL lat1_write got %0d edges want 2", e); end
        b_txn(0, 1, 10'h001, v1, e);
        b_i_read = 1; b_i_address = 10'h000;
        e = 0;
        do begin tick(); e++; end while (b_i_busywait && e < 40);
        n_checks++; if (e != 2) begin n_fail++; $display("FAIL lat1_rd0_latency got %0d want 2", e); end
        n_checks++; if (b_i_readdata !== v0) begin n_fail++; $display("FAIL lat1_rd0_data got %h want %h", b_i_readdata, v0); end
        b_i_read = 0; tick();
        b_i_read = 1; b_i_address = 10'h001;
        e = 0;
        do begin tick(); e++; end while (b_i_busywait && e < 40);
        n_checks++; if (e != 2) begin n_fail++; $display("FAIL lat1_rd1_latency got %0d want 2", e); end
        n_checks++; if (b_i_readdata !== v1) begin n_fail++; $display("FAIL lat1_rd1_data got %h want %h", b_i_readdata, v1); end
        n_checks++; if (b_d_readdata !== 128'd0) begin n_fail++; $display("FAIL lat1_d_held got %h want 0", b_d_readdata); end
        b_i_read = 0; tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reset_mid_write();
        test_simultaneous();
        test_read_write_both();
        test_withdraw();
        test_random();
        test_latency1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
